pc_sequencer: RTL

- Fetch-stage controller that drives the program counter register: computes its next value (PC_in) and its active-low load enable (PC_EN).
- Arbitrates between exception entry, branch and jump redirects, instruction-memory wait, load-use stalls and sequential fetch.
- Generates the matching IF/ID and ID/EX flush and hold controls.
- Sits between hazard/branch logic in ID/EX and the PC register in IF.

---
 rtl/mips_pkg.sv | 13 +
 rtl/pc_next_mux.sv | 35 +++
 rtl/pc_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-sequencer types and constants.
package mips_pkg;
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } seq_state_t;

    localparam int unsigned PC_STEP        = 4;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0080;
    // Address bits that are cleared on every redirect target.
    localparam logic [1:0]  ALIGN_MASK     = 2'b11;
endpackage

// File: rtl/pc_next_mux.sv
// Redirect priority select (exception > branch > jump) with target alignment and flush decode.
// Purely combinational; no backpressure of its own.
module pc_next_mux
    import mips_pkg::*;
#(
    parameter int unsigned          data_size  = 32,
    parameter logic [data_size-1:0] EXC_VECTOR = data_size'(EXC_VECTOR_DEF)
) (
    input  logic                 exc_req_i,
    input  logic                 branch_taken_i,
    input  logic [data_size-1:0] branch_target_i,
    input  logic                 jump_i,
    input  logic [data_size-1:0] jump_target_i,
    output logic                 redir_o,
    output logic [data_size-1:0] target_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_flush_o
);
    logic [data_size-1:0] raw_tgt;

    always_comb begin
        raw_tgt = jump_target_i;
        if (exc_req_i) begin
            raw_tgt = EXC_VECTOR;
        end else if (branch_taken_i) begin
            raw_tgt = branch_target_i;
        end
    end

    assign target_o      = {raw_tgt[data_size-1:2], raw_tgt[1:0] & ~ALIGN_MASK};
    assign redir_o       = exc_req_i | branch_taken_i | jump_i;
    assign if_id_flush_o = redir_o;
    // A jump resolves in ID, so only the younger IF/ID slot is wrong-path.
    assign id_ex_flush_o = exc_req_i | branch_taken_i;
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: next PC, active-low load enable, pipeline flush/hold.
// Outputs combinational from state/inputs; imem wait parks redirects in a one-entry pending slot.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned          data_size   = 32,
    parameter logic [3:0]           BOOT_CYCLES = 4'd2,
    parameter logic [data_size-1:0] EXC_VECTOR  = data_size'(EXC_VECTOR_DEF),
    parameter int unsigned          CNT_W       = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [data_size-1:0] PC_out,
    input  logic                 imem_ready,
    input  logic                 load_use_stall,
    input  logic                 branch_taken,
    input  logic [data_size-1:0] branch_target,
    input  logic                 jump,
    input  logic [data_size-1:0] jump_target,
    input  logic                 exc_req,
    output logic [data_size-1:0] PC_in,
    output logic                 PC_EN,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 if_id_hold,
    output logic [CNT_W-1:0]     stall_count
);
    seq_state_t           state_q, state_d;
    logic [3:0]           boot_cnt_q, boot_cnt_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [data_size-1:0] pend_tgt_q, pend_tgt_d;
    logic [CNT_W-1:0]     stall_cnt_q;

    logic                 redir;
    logic [data_size-1:0] redir_tgt;
    logic                 redir_if_flush, redir_ex_flush;
    logic [data_size-1:0] seq_pc;

    assign seq_pc = PC_out + data_size'(PC_STEP);

    pc_next_mux #(
        .data_size  (data_size),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_mux (
        .exc_req_i       (exc_req),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .redir_o         (redir),
        .target_o        (redir_tgt),
        .if_id_flush_o   (redir_if_flush),
        .id_ex_flush_o   (redir_ex_flush)
    );

    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_tgt_d  = pend_tgt_q;
        PC_in       = PC_out;
        PC_EN       = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if_id_hold  = 1'b0;
        case (state_q)
            ST_BOOT: begin
                PC_in       = '0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                boot_cnt_d  = boot_cnt_q - 4'd1;
                if (boot_cnt_q <= 4'd1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (redir) begin
                    if_id_flush = redir_if_flush;
                    id_ex_flush = redir_ex_flush;
                    if (imem_ready) begin
                        PC_in = redir_tgt;
                        PC_EN = 1'b0;
                    end else begin
                        pend_tgt_d = redir_tgt;
                        pend_vld_d = 1'b1;
                        state_d    = ST_WAIT;
                    end
                end else if (!imem_ready) begin
                    if_id_hold = 1'b1;
                    state_d    = ST_WAIT;
                end else if (load_use_stall) begin
                    if_id_hold  = 1'b1;
                    id_ex_flush = 1'b1;
                end else begin
                    PC_in = seq_pc;
                    PC_EN = 1'b0;
                end
            end
            ST_WAIT: begin
                if_id_hold = 1'b1;
                if (redir) begin
                    if_id_flush = redir_if_flush;
                    id_ex_flush = redir_ex_flush;
                    if (imem_ready) begin
                        PC_in      = redir_tgt;
                        PC_EN      = 1'b0;
                        if_id_hold = 1'b0;
                        pend_vld_d = 1'b0;
                        state_d    = ST_RUN;
                    end else begin
                        pend_tgt_d = redir_tgt;
                        pend_vld_d = 1'b1;
                    end
                end else if (imem_ready) begin
                    PC_EN      = 1'b0;
                    if_id_hold = 1'b0;
                    state_d    = ST_RUN;
                    if (pend_vld_q) begin
                        PC_in       = pend_tgt_q;
                        if_id_flush = 1'b1;
                        pend_vld_d  = 1'b0;
                    end else begin
                        PC_in = seq_pc;
                    end
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_BOOT;
            boot_cnt_q  <= BOOT_CYCLES;
            pend_vld_q  <= 1'b0;
            pend_tgt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
            if (PC_EN && (state_q != ST_BOOT) && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_count = stall_cnt_q;
endmodule
